// File: rtl/dpi_rsp_collector.sv
// Response collector: buffers DUT output words in a first-word-fall-through FIFO
// and hands them to the C monitor with a sequence number; reports done/timeout.
module dpi_rsp_collector #(
  parameter int DW          = 32,
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 1000,
  localparam int LW         = $clog2(DEPTH + 1),
  localparam int PW         = $clog2(DEPTH)
) (
  input  logic          v_clk,
  input  logic          v_rst,
  input  logic          start,
  input  logic [31:0]   exp_cnt,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          mon_valid,
  input  logic          mon_ready,
  output logic [DW-1:0] mon_data,
  output logic [31:0]   mon_seq,
  output logic [LW-1:0] level,
  output logic          done,
  output logic          timeout
);

  typedef enum logic [1:0] {IDLE, RUN, DONE, TMO} state_t;

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [31:0]   TMO_LIM  = 32'(TIMEOUT_CYC);

  state_t        state_q;
  logic [31:0]   exp_q;
  logic [31:0]   acc_q;
  logic [31:0]   pop_q;
  logic [31:0]   stall_q;
  logic [31:0]   stall_d;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [LW-1:0] cnt_q;
  logic          done_q;
  logic          tmo_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic push;
  logic pop;
  logic arm;

  // in_ready looks only at registered state: a same-cycle pop never frees a slot
  assign in_ready  = (state_q == RUN) && (cnt_q < FULL_LVL) && (acc_q < exp_q);
  assign mon_valid = (cnt_q != '0);
  assign mon_data  = mon_valid ? mem_q[rd_ptr_q] : '0;
  assign mon_seq   = pop_q;
  assign level     = cnt_q;
  assign done      = done_q;
  assign timeout   = tmo_q;

  assign push = in_valid && in_ready;
  assign pop  = mon_valid && mon_ready;
  assign arm  = start && (state_q != RUN);

  assign stall_d = push ? 32'd0 :
                   (stall_q == TMO_LIM) ? stall_q : stall_q + 32'd1;

  always_ff @(posedge v_clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge v_clk) begin
    if (v_rst) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      acc_q    <= '0;
      pop_q    <= '0;
      stall_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else if (arm) begin
      state_q  <= RUN;
      exp_q    <= exp_cnt;
      acc_q    <= '0;
      pop_q    <= '0;
      stall_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
        acc_q    <= acc_q + 32'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
        pop_q    <= pop_q + 32'd1;
      end
      if (push && !pop)      cnt_q <= cnt_q + LW'(1);
      else if (!push && pop) cnt_q <= cnt_q - LW'(1);

      if (state_q == RUN) begin
        stall_q <= stall_d;
        // timeout fires on the edge where the stall count reaches the limit
        if (pop_q == exp_q) begin
          state_q <= DONE;
          done_q  <= 1'b1;
        end else if ((TMO_LIM != 32'd0) && (stall_d == TMO_LIM)) begin
          state_q <= TMO;
          tmo_q   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dpi_rsp_collector.sv
// Scenario bench for dpi_rsp_collector: scoreboard of accepted words checked
// against every word popped by the monitor side, plus per-scenario checks.
module tb_dpi_rsp_collector;

  logic        clk = 1'b0;
  logic        v_rst;
  logic        start;
  logic [31:0] exp_cnt;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        mon_valid;
  logic        mon_ready;
  logic [31:0] mon_data;
  logic [31:0] mon_seq;
  logic [3:0]  level;
  logic        done;
  logic        timeout;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_seq = 0;

  always #5 clk = ~clk;

  dpi_rsp_collector #(.DW(32), .DEPTH(8), .TIMEOUT_CYC(16)) dut (
    .v_clk(clk), .v_rst(v_rst), .start(start), .exp_cnt(exp_cnt),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mon_valid(mon_valid), .mon_ready(mon_ready), .mon_data(mon_data),
    .mon_seq(mon_seq), .level(level), .done(done), .timeout(timeout)
  );

  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    if (!v_rst) begin
      if (mon_valid && mon_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: popped %0h with nothing expected", mon_data);
        end else begin
          e = sb_q.pop_front();
          if (mon_data !== e || mon_seq !== exp_seq) begin
            errors++;
            $display("FAIL sb_pop: got data %0h seq %0d, want data %0h seq %0d",
                     mon_data, mon_seq, e, exp_seq);
          end
        end
        exp_seq++;
      end
      if (in_valid && in_ready) sb_q.push_back(in_data);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [31:0] n);
    in_valid  = 1'b0;
    mon_ready = 1'b0;
    start     = 1'b1;
    exp_cnt   = n;
    tick();
    start = 1'b0;
    sb_q.delete();
    exp_seq = 0;
    checks++;
    if (done !== 1'b0 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL start_clear: done %b timeout %b, want 0 0", done, timeout);
    end
  endtask

  task automatic test_reset();
    v_rst = 1'b1; start = 1'b0; exp_cnt = 0; in_valid = 1'b0; in_data = 0; mon_ready = 1'b0;
    tick(); tick();
    v_rst = 1'b0;
    checks++;
    if ({in_ready, mon_valid, done, timeout} !== 4'b0000 || level !== 4'd0 ||
        mon_data !== 32'd0 || mon_seq !== 32'd0) begin
      errors++;
      $display("FAIL reset: rdy %b mval %b done %b tmo %b lvl %0d data %0h seq %0d, want all 0",
               in_ready, mon_valid, done, timeout, level, mon_data, mon_seq);
    end
  endtask

  task automatic test_basic();
    int c;
    do_start(4);
    mon_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_data = i;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL basic_ready: in_ready %b want 1 (word %0d)", in_ready, i);
      end
      tick();
      if (i == 1) begin
        checks++;
        if (mon_valid !== 1'b1 || mon_data !== 32'd1) begin
          errors++;
          $display("FAIL basic_latency: mon_valid %b data %0h, want 1 1", mon_valid, mon_data);
        end
      end
    end
    in_valid = 1'b0;
    c = 0;
    while (!done && c < 20) begin tick(); c++; end
    checks++;
    if (done !== 1'b1 || exp_seq !== 32'd4 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL basic_done: done %b pops %0d left %0d, want 1 4 0", done, exp_seq, sb_q.size());
    end
  endtask

  task automatic test_fill_and_full();
    int  n;
    int  c;
    logic acc;
    do_start(10);
    n = 0;
    in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = 100 + n;
      acc = in_ready;
      tick();
      if (acc) n++;
    end
    checks++;
    if (n != 8 || level !== 4'd8 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL fill: accepted %0d level %0d ready %b, want 8 8 0", n, level, in_ready);
    end
    // full FIFO: pop while offering a word; push must wait a cycle
    mon_ready = 1'b1;
    in_data = 100 + n;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop_ready: in_ready %b want 0", in_ready);
    end
    tick();
    mon_ready = 1'b0;
    checks++;
    if (level !== 4'd7 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_after_pop: level %0d ready %b, want 7 1", level, in_ready);
    end
    tick();
    n++;
    checks++;
    if (level !== 4'd8) begin
      errors++;
      $display("FAIL full_refill: level %0d want 8", level);
    end
    mon_ready = 1'b1;
    c = 0;
    while (!done && c < 60) begin
      if (n < 10) begin in_valid = 1'b1; in_data = 100 + n; end
      else in_valid = 1'b0;
      acc = in_valid && in_ready;
      tick();
      if (acc) n++;
      c++;
    end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || n != 10 || exp_seq !== 32'd10 || sb_q.size() != 0 || level !== 4'd0) begin
      errors++;
      $display("FAIL drain: done %b acc %0d pops %0d left %0d lvl %0d, want 1 10 10 0 0",
               done, n, exp_seq, sb_q.size(), level);
    end
  endtask

  task automatic test_timeout();
    int c;
    do_start(5);
    in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      in_data = 32'hA0 + k;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL tmo_ready: in_ready %b want 1", in_ready);
      end
      tick();
    end
    in_valid = 1'b0;
    c = 0;
    while (!timeout && c < 40) begin tick(); c++; end
    checks++;
    if (c != 16 || timeout !== 1'b1 || in_ready !== 1'b0 || level !== 4'd2 || done !== 1'b0) begin
      errors++;
      $display("FAIL timeout: cycles %0d tmo %b ready %b lvl %0d done %b, want 16 1 0 2 0",
               c, timeout, in_ready, level, done);
    end
    mon_ready = 1'b1;
    c = 0;
    while (mon_valid && c < 10) begin tick(); c++; end
    mon_ready = 1'b0;
    checks++;
    if (level !== 4'd0 || timeout !== 1'b1 || exp_seq !== 32'd2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL tmo_drain: lvl %0d tmo %b pops %0d, want 0 1 2", level, timeout, exp_seq);
    end
  endtask

  task automatic test_reset_midrun();
    int c;
    do_start(6);
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin in_data = 32'hC0 + k; tick(); end
    in_valid = 1'b0;
    checks++;
    if (level !== 4'd3) begin
      errors++;
      $display("FAIL mid_level: level %0d want 3", level);
    end
    v_rst = 1'b1;
    tick();
    v_rst = 1'b0;
    sb_q.delete();
    exp_seq = 0;
    checks++;
    if (level !== 4'd0 || mon_valid !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || mon_seq !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset: lvl %0d mval %b rdy %b done %b seq %0d, want 0 0 0 0 0",
               level, mon_valid, in_ready, done, mon_seq);
    end
    do_start(2);
    in_valid = 1'b1; in_data = 32'h55;
    tick();
    in_data = 32'h66;
    checks++;
    if (mon_valid !== 1'b1 || mon_data !== 32'h55 || mon_seq !== 32'd0) begin
      errors++;
      $display("FAIL mid_rerun_head: mval %b data %0h seq %0d, want 1 55 0", mon_valid, mon_data, mon_seq);
    end
    mon_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    c = 0;
    while (!done && c < 10) begin tick(); c++; end
    checks++;
    if (done !== 1'b1 || exp_seq !== 32'd2 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL mid_rerun_done: done %b pops %0d, want 1 2", done, exp_seq);
    end
  endtask

  task automatic test_zero_cnt();
    int  c;
    logic saw_ready;
    do_start(0);
    in_valid  = 1'b1;
    in_data   = 32'hDEAD;
    saw_ready = in_ready;
    c = 0;
    while (!done && c < 2) begin tick(); saw_ready |= in_ready; c++; end
    in_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || saw_ready !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL zero_cnt: done %b saw_ready %b lvl %0d, want 1 0 0", done, saw_ready, level);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill_and_full();
    test_timeout();
    test_reset_midrun();
    test_zero_cnt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
